xoodyak_loader: RTL and testbench

Upstream input stage for the `xoodyak` AEAD core. It accepts a job as a stream of 32-bit words over a valid/ready handshake and assembles the core's wide operand fields. It then issues the core's single-cycle `start` and holds all operands stable until the core reports `sqzdone`. It replaces the hard-wired operand assigns used in bench-level bring-up, so encrypt and decrypt jobs can be fed back-to-back from a narrow bus.

---
 rtl/xoodyak_pkg.sv | 39 +++
 rtl/xoodyak_loader_if.sv | 11 +
 rtl/xood_field_shift.sv | 26 ++
 rtl/xoodyak_loader.sv | 93 +++++++++
 tb/tb_xoodyak_loader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/xoodyak_pkg.sv
// Shared types and constants for the xoodyak operand loader.
// The state enum and field sizes are used by both the loader and its bench-facing top.
package xoodyak_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEY   = 3'd1,
    NONCE = 3'd2,
    AD    = 3'd3,
    TEXT  = 3'd4,
    TAG   = 3'd5,
    START = 3'd6,
    BUSY  = 3'd7
  } ld_state_t;

  localparam int KEY_W      = 128;
  localparam int TEXT_W     = 192;
  localparam int WORDS_128  = 4;
  localparam int WORDS_TEXT = 6;
  localparam int CNT_W      = 3;

  // Counter value of the final word of the field loaded in state s.
  function automatic logic [CNT_W-1:0] field_last(input ld_state_t s);
    if (s == TEXT) return CNT_W'(WORDS_TEXT - 1);
    return CNT_W'(WORDS_128 - 1);
  endfunction

  // Loading state that follows s once its field is complete.
  function automatic ld_state_t field_next(input ld_state_t s, input logic op);
    case (s)
      KEY:     return NONCE;
      NONCE:   return AD;
      AD:      return TEXT;
      TEXT:    return op ? TAG : START;
      default: return START;
    endcase
  endfunction

endpackage

// File: rtl/xoodyak_loader_if.sv
// Word-stream handshake feeding the loader: data/valid from the source, ready back.
interface xoodyak_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, in_valid, input in_ready);
  modport slave  (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/xood_field_shift.sv
// Wide operand register filled one bus word at a time, first word landing in the MSBs.
module xood_field_shift #(
  parameter int W  = 128,
  parameter int DW = 32
) (
  input  logic          eph1,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [W-1:0]  q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)     q_d = '0;
    else if (en) q_d = {q_q[W-DW-1:0], d};
  end

  // NOTE: state flops use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge eph1) q_q <= q_d;

  assign q = q_q;

endmodule

// File: rtl/xoodyak_loader.sv
// Assembles a xoodyak job from a 32-bit word stream, issues start and holds operands
// until the core signals sqzdone.
module xoodyak_loader
  import xoodyak_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                eph1,
  input  logic                reset,
  xoodyak_loader_if.slave     in_if,
  input  logic                core_done,
  output logic                start,
  output logic                opmode,
  output logic [KEY_W-1:0]    key,
  output logic [KEY_W-1:0]    nonce,
  output logic [KEY_W-1:0]    assodata,
  output logic [TEXT_W-1:0]   textin,
  output logic [KEY_W-1:0]    verification_data,
  output logic                busy
);

  ld_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             opmode_q, opmode_d;
  logic             accept;

  assign in_if.in_ready = (state_q != START) && (state_q != BUSY);
  assign accept         = in_if.in_valid && in_if.in_ready;

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opmode_d = opmode_q;
    case (state_q)
      IDLE: if (accept) begin
        opmode_d = in_if.in_data[0];
        state_d  = KEY;
      end
      KEY, NONCE, AD, TEXT, TAG: if (accept) begin
        if (cnt_q == field_last(state_q)) state_d = field_next(state_q, opmode_q);
        else                              cnt_d   = cnt_q + CNT_W'(1);
      end
      START:   state_d = BUSY;
      BUSY:    if (core_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge eph1) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opmode_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opmode_q <= opmode_d;
    end
  end

  xood_field_shift #(.W(KEY_W), .DW(WORD_W)) u_key (
    .eph1(eph1), .clr(reset), .en(accept && state_q == KEY),
    .d(in_if.in_data), .q(key)
  );

  xood_field_shift #(.W(KEY_W), .DW(WORD_W)) u_nonce (
    .eph1(eph1), .clr(reset), .en(accept && state_q == NONCE),
    .d(in_if.in_data), .q(nonce)
  );

  xood_field_shift #(.W(KEY_W), .DW(WORD_W)) u_ad (
    .eph1(eph1), .clr(reset), .en(accept && state_q == AD),
    .d(in_if.in_data), .q(assodata)
  );

  xood_field_shift #(.W(TEXT_W), .DW(WORD_W)) u_text (
    .eph1(eph1), .clr(reset), .en(accept && state_q == TEXT),
    .d(in_if.in_data), .q(textin)
  );

  // Only reachable on decrypt jobs, so encrypt leaves the previous tag in place.
  xood_field_shift #(.W(KEY_W), .DW(WORD_W)) u_tag (
    .eph1(eph1), .clr(reset), .en(accept && state_q == TAG),
    .d(in_if.in_data), .q(verification_data)
  );

  assign start  = (state_q == START);
  assign busy   = (state_q == START) || (state_q == BUSY);
  assign opmode = opmode_q;

endmodule

// File: tb/tb_xoodyak_loader.sv
// Directed and randomized jobs for xoodyak_loader, checked against a field-level model.
module tb_xoodyak_loader;

  logic         eph1 = 1'b0;
  logic         reset = 1'b1;
  logic         core_done = 1'b0;
  logic         start, opmode, busy;
  logic [127:0] key, nonce, assodata, verification_data;
  logic [191:0] textin;

  int vectors = 0;
  int miscompares = 0;

  // Current job, described as fields; the word stream is derived from these.
  logic         j_op;
  logic [127:0] j_key, j_nonce, j_ad, j_tag;
  logic [191:0] j_text;
  logic [31:0]  words[$];

  // Expected output registers.
  logic         e_op;
  logic [127:0] e_key, e_nonce, e_ad, e_vd;
  logic [191:0] e_text;

  always #5 eph1 = ~eph1;

  xoodyak_loader_if #(.WORD_W(32)) bus ();

  xoodyak_loader #(.WORD_W(32)) dut (
    .eph1(eph1), .reset(reset), .in_if(bus), .core_done(core_done),
    .start(start), .opmode(opmode), .key(key), .nonce(nonce),
    .assodata(assodata), .textin(textin),
    .verification_data(verification_data), .busy(busy)
  );

  task automatic tick();
    @(posedge eph1);
    #1;
  endtask

  task automatic checkb(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkv(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input string tag);
    checkb({tag, "_opmode"}, opmode, e_op);
    checkv({tag, "_key"}, 192'(key), 192'(e_key));
    checkv({tag, "_nonce"}, 192'(nonce), 192'(e_nonce));
    checkv({tag, "_ad"}, 192'(assodata), 192'(e_ad));
    checkv({tag, "_text"}, textin, e_text);
    checkv({tag, "_vd"}, 192'(verification_data), 192'(e_vd));
  endtask

  task automatic build_job(input logic op, input logic [30:0] hdr_hi);
    j_op  = op;
    words = {};
    words.push_back({hdr_hi, op});
    for (int i = 0; i < 4; i++) words.push_back(j_key[127-32*i -: 32]);
    for (int i = 0; i < 4; i++) words.push_back(j_nonce[127-32*i -: 32]);
    for (int i = 0; i < 4; i++) words.push_back(j_ad[127-32*i -: 32]);
    for (int i = 0; i < 6; i++) words.push_back(j_text[191-32*i -: 32]);
    if (op) for (int i = 0; i < 4; i++) words.push_back(j_tag[127-32*i -: 32]);
  endtask

  task automatic rand_fields();
    j_key   = {$urandom, $urandom, $urandom, $urandom};
    j_nonce = {$urandom, $urandom, $urandom, $urandom};
    j_ad    = {$urandom, $urandom, $urandom, $urandom};
    j_text  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    j_tag   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Present the first n words of the job, optionally with idle gaps of 1..stall_max cycles.
  task automatic feed(input int n, input int stall_max, input bit stray_key);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = (stall_max > 0) ? int'($urandom_range(stall_max, 1)) : 0;
      repeat (gap) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        tick();
        checkb("stall_no_start", start, 1'b0);
      end
      if (stray_key && i == 2) core_done = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = words[i];
      checkb("ready_while_loading", bus.in_ready, 1'b1);
      checkb("no_early_start", start, 1'b0);
      tick();
      core_done = 1'b0;
    end
    bus.in_valid = 1'b0;
  endtask

  // Called in the cycle after the last word: checks start, the BUSY hold and completion.
  task automatic complete(input bit stray_start, input int lat, input bit hold_next,
                          input logic [31:0] next_hdr);
    checkb("start_after_last", start, 1'b1);
    checkb("busy_with_start", busy, 1'b1);
    checkb("ready_low_start", bus.in_ready, 1'b0);
    e_op = j_op; e_key = j_key; e_nonce = j_nonce; e_ad = j_ad; e_text = j_text;
    if (j_op) e_vd = j_tag;
    check_fields("issued");
    if (hold_next) begin
      bus.in_valid = 1'b1;
      bus.in_data  = next_hdr;
    end
    if (stray_start) core_done = 1'b1;
    tick();
    core_done = 1'b0;
    repeat (lat) begin
      checkb("single_start", start, 1'b0);
      checkb("busy_hold", busy, 1'b1);
      checkb("ready_low_busy", bus.in_ready, 1'b0);
      tick();
    end
    check_fields("held_in_busy");
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checkb("done_ready", bus.in_ready, 1'b1);
    checkb("done_not_busy", busy, 1'b0);
    checkb("done_no_start", start, 1'b0);
  endtask

  task automatic reset_check(input string tag);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    e_op = 1'b0; e_key = '0; e_nonce = '0; e_ad = '0; e_text = '0; e_vd = '0;
    check_fields(tag);
    checkb({tag, "_start"}, start, 1'b0);
    checkb({tag, "_busy"}, busy, 1'b0);
    checkb({tag, "_ready"}, bus.in_ready, 1'b1);
    reset = 1'b0;
    tick();
    checkb({tag, "_ready_after"}, bus.in_ready, 1'b1);
    checkb({tag, "_no_start_after"}, start, 1'b0);
  endtask

  initial begin
    logic [31:0] r;
    logic        op;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) tick();
    reset_check("reset");

    // Stray done while idle.
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    checkb("idle_done_ready", bus.in_ready, 1'b1);
    checkb("idle_done_busy", busy, 1'b0);

    // Directed encrypt job.
    j_key   = 128'h30313233_34353637_38393a3b_3c3d3e3f;
    j_nonce = 128'h41424344_45464748_494a4b4c_4d4e4f50;
    j_ad    = 128'h61626364_65666768_696a6b6c_6d6e6f70;
    j_text  = 192'h41424344_45464748_494a4b4c_4d4e4f50_51525354_55565758;
    j_tag   = 128'h0;
    build_job(1'b0, 31'h0);
    feed(19, 0, 1'b0);
    checkv("enc_key_literal", 192'(key), 192'h30313233_34353637_38393a3b_3c3d3e3f);
    complete(1'b0, 3, 1'b0, 32'h0);

    // Directed decrypt job with the same operands plus tag.
    j_tag = 128'hdeadbeef_00112233_44556677_8899aabb;
    build_job(1'b1, 31'h0);
    feed(23, 0, 1'b0);
    checkv("dec_tag_literal", 192'(verification_data), 192'hdeadbeef_00112233_44556677_8899aabb);
    complete(1'b0, 2, 1'b0, 32'h0);

    // Randomized jobs with stalls; job 0 is encrypt so the previous tag must survive.
    for (int k = 0; k < 6; k++) begin
      rand_fields();
      r  = $urandom;
      op = (k == 0) ? 1'b0 : r[0];
      build_job(op, r[31:1]);
      feed(op ? 23 : 19, 3, k == 1);
      complete(k == 2, 1 + (k % 3), 1'b0, 32'h0);
    end

    // Back-pressure: next header held valid through BUSY must become the next job's header.
    rand_fields();
    build_job(1'b1, 31'h1234);
    feed(23, 0, 1'b0);
    r  = $urandom;
    op = r[0];
    complete(1'b0, 4, 1'b1, {r[31:1], op});
    rand_fields();
    build_job(op, r[31:1]);
    feed(op ? 23 : 19, 0, 1'b0);
    complete(1'b0, 1, 1'b0, 32'h0);

    // Reset while loading text, then a clean job.
    rand_fields();
    build_job(1'b1, 31'h0);
    feed(15, 1, 1'b0);
    reset_check("reset_text");
    rand_fields();
    build_job(1'b0, 31'h7);
    feed(19, 0, 1'b0);
    complete(1'b0, 2, 1'b0, 32'h0);

    // Reset while the core is busy, then a clean job.
    rand_fields();
    build_job(1'b1, 31'h0);
    feed(23, 0, 1'b0);
    checkb("pre_reset_start", start, 1'b1);
    tick();
    checkb("pre_reset_busy", busy, 1'b1);
    reset_check("reset_busy");
    rand_fields();
    build_job(1'b1, 31'h5);
    feed(23, 2, 1'b0);
    complete(1'b0, 2, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
